// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data-memory stage.
//   size_e  - request access size encoding (byte / half / word / reserved)
//   state_e - request FSM states
//   WCNT_W  - width of the wait-state counter (supports 0..15 wait states)
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int WCNT_W = 4;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian lane steering for data_mem_ctrl.
//   size      in  access size
//   lane      in  byte offset of the access inside its 32-bit word
//   sext      in  sign-extend sub-word loads when 1
//   wdata     in  right-aligned store data
//   rword     in  full memory word being loaded
//   byte_en   out byte lanes written by a store
//   wdata_rep out store data replicated across all candidate lanes
//   rdata     out load result shifted to bit 0 and extended
module mem_lane_align
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  // Only the low half-word of the shifted word is ever needed for sub-word loads.
  logic [15:0] shifted;
  assign shifted = 16'(rword >> {lane, 3'b000});

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = 32'h0;
    rdata     = 32'h0;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        // Aligned halves live in lanes 0-1 or 2-3; lane[0] is rejected upstream.
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        byte_en   = 4'b1111;
        wdata_rep = wdata;
        rdata     = rword;
      end
      default: begin
        byte_en   = 4'b0000;
        wdata_rep = 32'h0;
        rdata     = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage data memory with valid/ready request handshake,
// configurable wait states, sub-word access and error flagging.
//   clk        in  clock
//   rst        in  asynchronous active-low reset
//   req_valid  in  request present
//   req_ready  out request accepted when req_valid && req_ready at a rising edge
//   req_write  in  1 = store, 0 = load
//   req_size   in  00 byte, 01 half, 10 word, 11 reserved
//   req_signed in  sign-extend sub-word loads
//   req_addr   in  byte address
//   req_wdata  in  right-aligned store data
//   rsp_valid  out one-cycle response pulse
//   rsp_rdata  out load result (0 for stores and errors)
//   rsp_err    out misaligned / out-of-range / reserved-size access
//   busy       out controller not idle (pipeline stall)
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int BASE_ADDR   = 1024,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int                IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_e              state_reg;
  logic [WCNT_W-1:0]   wcnt_reg;
  logic                write_reg;
  size_e               size_reg;
  logic                signed_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic                ready_reg;
  logic                busy_reg;
  logic                rsp_valid_reg;
  logic [31:0]         rsp_rdata_reg;
  logic                rsp_err_reg;

  // With no wait states the access commits on the accept edge itself, so the
  // live request is used in IDLE and the latched copy in WAIT.
  logic              in_idle;
  logic              cur_write;
  size_e             cur_size;
  logic              cur_signed;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;

  assign in_idle    = (state_reg == ST_IDLE);
  assign cur_write  = in_idle ? req_write           : write_reg;
  assign cur_size   = in_idle ? size_e'(req_size)   : size_reg;
  assign cur_signed = in_idle ? req_signed          : signed_reg;
  assign cur_addr   = in_idle ? req_addr            : addr_reg;
  assign cur_wdata  = in_idle ? req_wdata           : wdata_reg;

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word_off;
  logic              acc_err;
  logic [IDX_W-1:0]  mem_idx;

  assign offset   = cur_addr - BASE;
  assign word_off = offset >> 2;
  assign mem_idx  = offset[IDX_W+1:2];
  assign acc_err  = (cur_addr < BASE)
                 || (32'(word_off) >= 32'(DEPTH))
                 || (cur_size == SZ_HALF && offset[0])
                 || (cur_size == SZ_WORD && offset[1:0] != 2'b00)
                 || (cur_size == SZ_RSVD);

  // Commit happens on the edge that enters RESP. An asynchronous reset forces
  // IDLE with a zero counter, so an aborted WAIT can never reach this term.
  logic commit;
  assign commit = (in_idle && req_valid && (WAIT_CYCLES == 0))
               || (state_reg == ST_WAIT && wcnt_reg == '0);

  logic [31:0] mem [DEPTH];
  logic [31:0] rword;
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep;
  logic [31:0] load_data;

  assign rword = mem[mem_idx];

  mem_lane_align u_align (
    .size      (cur_size),
    .lane      (offset[1:0]),
    .sext      (cur_signed),
    .wdata     (cur_wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .rdata     (load_data)
  );

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && cur_write && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[mem_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      wcnt_reg      <= '0;
      write_reg     <= 1'b0;
      size_reg      <= SZ_BYTE;
      signed_reg    <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= 32'h0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            write_reg  <= req_write;
            size_reg   <= size_e'(req_size);
            signed_reg <= req_signed;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state_reg <= ST_WAIT;
              wcnt_reg  <= WCNT_W'(WAIT_CYCLES - 1);
            end else begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wcnt_reg == '0) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
          end else begin
            wcnt_reg <= wcnt_reg - 1'b1;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
      if (commit) begin
        rsp_err_reg   <= acc_err;
        rsp_rdata_reg <= (acc_err || cur_write) ? 32'h0 : load_data;
      end
    end
  end

  assign req_ready = ready_reg;
  assign busy      = busy_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: self-checking bench for data_mem_ctrl. Instance 0 has no
// wait states, instance 1 has three. A byte-array model predicts results.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [15:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];
  logic        busy       [2];

  int checks = 0;
  int errors = 0;

  // Reference model: one byte per memory byte offset, plus a written flag.
  logic [7:0] mdl [2][1024];
  bit         kn  [2][1024];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(256), .BASE_ADDR(1024), .ADDR_W(16), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

  data_mem_ctrl #(.DEPTH(256), .BASE_ADDR(1024), .ADDR_W(16), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

  // Applies an access to the model and predicts its response.
  function automatic void model(input int d, input bit wr, input int sz, input bit sg,
                                input int addr, input logic [31:0] wd,
                                output logic [31:0] exp_rd, output bit exp_err,
                                output bit rd_known);
    int off, nb;
    longint v;
    off      = addr - 1024;
    exp_err  = (addr < 1024) || (off / 4 >= 256) || (sz == 1 && off % 2 != 0) ||
               (sz == 2 && off % 4 != 0) || (sz == 3);
    exp_rd   = 32'h0;
    rd_known = 1'b1;
    if (!exp_err) begin
      nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
      if (wr) begin
        for (int i = 0; i < nb; i++) begin
          mdl[d][off+i] = wd[8*i +: 8];
          kn[d][off+i]  = 1'b1;
        end
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) begin
          if (!kn[d][off+i]) rd_known = 1'b0;
          v = v + (longint'(mdl[d][off+i]) << (8*i));
        end
        if (sg && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8*nb));
        exp_rd = v[31:0];
      end
    end
  endfunction

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 16'($urandom_range(16'h03F0, 16'h0810));
    return 16'(16'h0400 + $urandom_range(0, 31));
  endfunction

  task automatic rand_req(input int d);
    req_write[d]  = 1'($urandom_range(0, 1));
    req_size[d]   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    req_signed[d] = 1'($urandom_range(0, 1));
    req_addr[d]   = rand_addr();
    req_wdata[d]  = $urandom;
  endtask

  // Issues one request and waits for its response. lat counts edges after the
  // accept edge before rsp_valid is seen; one_wide reports a single-cycle pulse.
  task automatic access(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [15:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output bit one_wide);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = wr; req_size[d] = sz;
    req_signed[d] = sg; req_addr[d] = addr; req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout inst%0d: req_ready stayed 0 for %0d cycles, required 1", d, n);
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 0;
    while (!rsp_valid[d] && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(posedge clk); #1;
    one_wide = !rsp_valid[d];
  endtask

  task automatic test_reset();
    #12;
    for (int d = 0; d < 2; d++) begin
      checks += 5;
      if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL rst_ready inst%0d: got %b expected 1", d, req_ready[d]); end
      if (busy[d] !== 1'b0) begin errors++; $display("FAIL rst_busy inst%0d: got %b expected 0", d, busy[d]); end
      if (rsp_valid[d] !== 1'b0) begin errors++; $display("FAIL rst_valid inst%0d: got %b expected 0", d, rsp_valid[d]); end
      if (rsp_rdata[d] !== 32'h0) begin errors++; $display("FAIL rst_rdata inst%0d: got %h expected 0", d, rsp_rdata[d]); end
      if (rsp_err[d] !== 1'b0) begin errors++; $display("FAIL rst_err inst%0d: got %b expected 0", d, rsp_err[d]); end
    end
    @(negedge clk); rst[0] = 1'b1; rst[1] = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks += 3;
      if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL post_rst_ready inst%0d: got %b expected 1", d, req_ready[d]); end
      if (busy[d] !== 1'b0) begin errors++; $display("FAIL post_rst_busy inst%0d: got %b expected 0", d, busy[d]); end
      if (rsp_valid[d] !== 1'b0) begin errors++; $display("FAIL post_rst_valid inst%0d: got %b expected 0", d, rsp_valid[d]); end
    end
  endtask

  typedef struct {
    bit wr; logic [1:0] sz; bit sg; logic [15:0] addr; logic [31:0] wd;
    logic [31:0] rd; bit er; bit chk;
  } vec_t;

  task automatic test_directed();
    vec_t tbl [14];
    logic [31:0] rd, erd; logic er; int lat; bit ow, eer, kn_ok;
    tbl[0]  = '{1, 2'b10, 0, 16'h0404, 32'hDEADBEEF, 32'h0,        0, 1};
    tbl[1]  = '{0, 2'b10, 0, 16'h0404, 32'h0,        32'hDEADBEEF, 0, 1};
    tbl[2]  = '{1, 2'b00, 0, 16'h0405, 32'h00000080, 32'h0,        0, 1};
    tbl[3]  = '{0, 2'b00, 1, 16'h0405, 32'h0,        32'hFFFFFF80, 0, 1};
    tbl[4]  = '{0, 2'b00, 0, 16'h0405, 32'h0,        32'h00000080, 0, 1};
    tbl[5]  = '{0, 2'b10, 0, 16'h0404, 32'h0,        32'hDEAD80EF, 0, 1};
    tbl[6]  = '{0, 2'b01, 1, 16'h0406, 32'h0,        32'hFFFFDEAD, 0, 1};
    tbl[7]  = '{1, 2'b01, 0, 16'h0405, 32'h00001234, 32'h0,        1, 1};
    tbl[8]  = '{0, 2'b10, 0, 16'h0404, 32'h0,        32'hDEAD80EF, 0, 1};
    tbl[9]  = '{0, 2'b10, 0, 16'h0406, 32'h0,        32'h0,        1, 1};
    tbl[10] = '{0, 2'b11, 0, 16'h0404, 32'h0,        32'h0,        1, 1};
    tbl[11] = '{1, 2'b10, 0, 16'h03FC, 32'h11111111, 32'h0,        1, 1};
    tbl[12] = '{1, 2'b10, 0, 16'h0800, 32'h22222222, 32'h0,        1, 1};
    tbl[13] = '{0, 2'b10, 0, 16'h07FC, 32'h0,        32'h0,        0, 0};
    for (int i = 0; i < 14; i++) begin
      access(0, tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd, rd, er, lat, ow);
      model(0, tbl[i].wr, int'(tbl[i].sz), tbl[i].sg, int'(tbl[i].addr), tbl[i].wd, erd, eer, kn_ok);
      $display("dir[%0d] wr=%0d sz=%0d addr=%h rdata=%h err=%0d lat=%0d", i, tbl[i].wr, tbl[i].sz, tbl[i].addr, rd, er, lat);
      checks += 3;
      if (er !== tbl[i].er) begin errors++; $display("FAIL dir_err[%0d]: got %b expected %b", i, er, tbl[i].er); end
      if (lat != 0) begin errors++; $display("FAIL dir_latency[%0d]: got %0d edges expected 1", i, lat + 1); end
      if (!ow) begin errors++; $display("FAIL dir_pulse_width[%0d]: rsp_valid wider than 1 cycle, expected 1", i); end
      if (tbl[i].chk) begin
        checks++;
        if (rd !== tbl[i].rd) begin errors++; $display("FAIL dir_rdata[%0d]: got %h expected %h", i, rd, tbl[i].rd); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd; logic er; int lat; bit ow, eer, kn_ok;
    for (int i = 0; i < 60; i++) begin
      rand_req(0);
      access(0, req_write[0], req_size[0], req_signed[0], req_addr[0], req_wdata[0], rd, er, lat, ow);
      model(0, req_write[0], int'(req_size[0]), req_signed[0], int'(req_addr[0]), req_wdata[0], erd, eer, kn_ok);
      $display("rnd[%0d] wr=%0d sz=%0d sg=%0d addr=%h rdata=%h err=%0d", i, req_write[0], req_size[0], req_signed[0], req_addr[0], rd, er);
      checks += 2;
      if (er !== eer) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, er, eer); end
      if (!ow || lat != 0) begin errors++; $display("FAIL rnd_timing[%0d]: lat %0d width_ok %0d expected 0/1", i, lat, ow); end
      if (kn_ok) begin
        checks++;
        if (rd !== erd) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", i, rd, erd); end
      end
    end
  endtask

  // Continuous req_valid on the 3-wait-state instance: timeline and data checks.
  task automatic test_back_to_back();
    logic [31:0] q_rd [$];
    bit q_er [$], q_kn [$];
    logic [31:0] erd; bit eer, ekn, acc, exp_busy;
    int last_acc = -100, nacc = 0, since;
    @(negedge clk);
    rand_req(1);
    req_valid[1] = 1'b1;
    for (int e = 0; e < 60; e++) begin
      acc = req_ready[1];
      if (acc) begin
        model(1, req_write[1], int'(req_size[1]), req_signed[1], int'(req_addr[1]), req_wdata[1], erd, eer, ekn);
        q_rd.push_back(erd); q_er.push_back(eer); q_kn.push_back(ekn);
      end
      @(posedge clk); #1;
      if (acc) begin
        if (nacc > 0) begin
          checks++;
          if (e - last_acc != 5) begin errors++; $display("FAIL b2b_spacing: got %0d cycles expected 5", e - last_acc); end
        end
        $display("b2b accept edge=%0d", e);
        last_acc = e; nacc++;
        rand_req(1);
      end
      since = e - last_acc;
      exp_busy = (since <= 3);
      checks += 3;
      if (req_ready[1] !== !exp_busy) begin errors++; $display("FAIL b2b_ready edge%0d: got %b expected %b", e, req_ready[1], !exp_busy); end
      if (busy[1] !== exp_busy) begin errors++; $display("FAIL b2b_busy edge%0d: got %b expected %b", e, busy[1], exp_busy); end
      if (rsp_valid[1] !== (since == 3)) begin errors++; $display("FAIL b2b_rsp_valid edge%0d: got %b expected %b", e, rsp_valid[1], since == 3); end
      if (rsp_valid[1] === 1'b1 && q_rd.size() > 0) begin
        erd = q_rd.pop_front(); eer = q_er.pop_front(); ekn = q_kn.pop_front();
        checks++;
        if (rsp_err[1] !== eer) begin errors++; $display("FAIL b2b_err edge%0d: got %b expected %b", e, rsp_err[1], eer); end
        if (ekn) begin
          checks++;
          if (rsp_rdata[1] !== erd) begin errors++; $display("FAIL b2b_rdata edge%0d: got %h expected %h", e, rsp_rdata[1], erd); end
        end
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    checks++;
    if (nacc < 10) begin errors++; $display("FAIL b2b_accept_count: got %0d expected at least 10", nacc); end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er; int lat; bit ow, eer, ekn, pulsed;
    access(1, 1'b1, 2'b10, 1'b0, 16'h0410, 32'hCAFEF00D, rd, er, lat, ow);
    model(1, 1'b1, 2, 1'b0, 16'h0410, 32'hCAFEF00D, erd, eer, ekn);
    checks += 2;
    if (er !== 1'b0) begin errors++; $display("FAIL abort_prestore_err: got %b expected 0", er); end
    if (lat != 3) begin errors++; $display("FAIL abort_prestore_latency: got %0d edges expected 4", lat + 1); end
    // Store that gets aborted while waiting.
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_size[1] = 2'b10;
    req_signed[1] = 1'b0; req_addr[1] = 16'h0410; req_wdata[1] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #2;
    rst[1] = 1'b0;
    #1;
    checks += 5;
    if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", req_ready[1]); end
    if (busy[1] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy[1]); end
    if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", rsp_valid[1]); end
    if (rsp_rdata[1] !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", rsp_rdata[1]); end
    if (rsp_err[1] !== 1'b0) begin errors++; $display("FAIL abort_err: got %b expected 0", rsp_err[1]); end
    pulsed = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (rsp_valid[1]) pulsed = 1'b1; end
    @(negedge clk); rst[1] = 1'b1;
    repeat (5) begin @(posedge clk); #1; if (rsp_valid[1]) pulsed = 1'b1; end
    checks++;
    if (pulsed) begin errors++; $display("FAIL abort_no_pulse: rsp_valid got 1 expected 0"); end
    access(1, 1'b0, 2'b10, 1'b0, 16'h0410, 32'h0, rd, er, lat, ow);
    model(1, 1'b0, 2, 1'b0, 16'h0410, 32'h0, erd, eer, ekn);
    $display("abort reload addr=0410 rdata=%h err=%0d", rd, er);
    checks += 2;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_reload: got %h expected cafef00d", rd); end
    if (rd !== erd) begin errors++; $display("FAIL abort_reload_model: got %h expected %h", rd, erd); end
    // Reset during the RESP cycle clears the pulse at once.
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 16'h0410;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL resp_abort_pre: rsp_valid got %b expected 1", rsp_valid[1]); end
    #2 rst[1] = 1'b0;
    #1;
    checks++;
    if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL resp_abort_clear: rsp_valid got %b expected 0", rsp_valid[1]); end
    @(negedge clk); rst[1] = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'b00;
      req_signed[d] = 1'b0; req_addr[d] = 16'h0; req_wdata[d] = 32'h0;
    end
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data-memory stage for the MEM pipeline stage, the successor of the fixed 256-word, single-cycle data memory. It translates CPU byte addresses into word indices from a configurable base. It supports byte, half-word and word loads and stores with sign or zero extension, and models a configurable number of memory wait states behind a valid/ready request handshake. It also flags misaligned and out-of-range accesses instead of silently aliasing them.

## Interface
- DEPTH, 256: number of 32-bit words; power of two.
- BASE_ADDR, 1024: byte address mapped to word 0.
- ADDR_W, 16: request address width.
- WAIT_CYCLES, 0: extra wait states per access (0..15).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: sign-extend when 1, zero-extend when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or reserved-size access; valid with rsp_valid.
- busy  out  1  state != IDLE; drives the pipeline stall.

## Operation
- FSM has three states:
  - IDLE: req_ready=1. On accept, latch the request, then go to WAIT if WAIT_CYCLES>0 (wait counter = WAIT_CYCLES-1), otherwise go to RESP.
  - WAIT: req_ready=0. Decrement the counter; at 0 go to RESP.
  - RESP: rsp_valid=1 for exactly this cycle, req_ready=0; go to IDLE next edge.
- The access commits on the edge entering RESP. A store writes its byte lanes at that edge; a load registers rsp_rdata at that edge.
- Address and error rules:
  - offset = req_addr - BASE_ADDR.
  - index = offset >> 2; lane = offset[1:0].
  - err = (req_addr < BASE_ADDR) || (index >= DEPTH) || (size==01 && offset[0]) || (size==10 && offset[1:0]!=0) || (size==11).
  - On err: no memory write, rsp_rdata=0, rsp_err=1.
- Little-endian lanes:
  - A byte access uses lane bits [8*lane+7 : 8*lane].
  - A half access uses lane 0 or 2.
  - Stores write only the addressed bytes; the other bytes of the word are preserved.
- Loads shift the addressed bytes to bit 0, then extend per req_signed. Word loads ignore req_signed.
- Memory array contents are not reset and stay uninitialised until written.

## Timing
- Reset state: IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
- Latency: rsp_valid is high in the cycle following WAIT_CYCLES+1 edges after the accept edge.
- Throughput: one request per WAIT_CYCLES+2 cycles. No back-to-back acceptance from RESP.
- Request inputs are ignored outside IDLE; the requester must hold its request until req_ready is sampled high.
- Reset asserted in WAIT or RESP aborts the request:
  - A store not yet committed is never written.
  - A RESP pulse in progress is cleared immediately.
- A load following a store to the same word returns the new data, because the store completes before the load is accepted.

## Structure
- Package mem_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
  - the state enum (ST_IDLE, ST_WAIT, ST_RESP);
  - the WAIT counter width constant (4).
- Sub-module mem_lane_align is purely combinational and contains:
  - store byte-enable and write-data replication;
  - load shift plus sign/zero extension.
- The top level holds the FSM, request latch, address check and memory array.

## Test plan
All scenarios use BASE_ADDR=1024 and DEPTH=256.
- Word round trip, WAIT_CYCLES=0: store 0xDEADBEEF at 0x0404, then load word at 0x0404 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid one edge after accept, one cycle wide.
- Sub-word access, after the word round trip: store byte 0x80 at 0x0405.
  - Signed byte load at 0x0405 -> 0xFFFFFF80; unsigned -> 0x00000080.
  - Word load at 0x0404 -> 0xDEAD80EF.
  - Signed half load at 0x0406 -> 0xFFFFDEAD.
- Alignment and size errors:
  - Half store at 0x0405 -> rsp_err=1 and memory unchanged; a word load at 0x0404 afterwards still returns 0xDEAD80EF.
  - Word load at 0x0406 -> rsp_err=1, rsp_rdata=0.
  - req_size=11 -> rsp_err=1.
- Range errors: store to 0x03FC and to 0x0800 -> rsp_err=1, no write; load at 0x07FC -> rsp_err=0.
- Wait states, WAIT_CYCLES=3: req_valid held high continuously.
  - Each request's rsp_valid arrives 4 edges after its accept edge.
  - req_ready stays 0 for 4 cycles after each accept.
  - Accepts are spaced exactly 5 cycles apart.
  - busy matches state != IDLE throughout.
- Reset mid-access, WAIT_CYCLES=3: assert rst during WAIT of a store of 0x12345678 to 0x0410.
  - All outputs return to reset values asynchronously; rsp_valid never pulses.
  - A later load at 0x0410 returns the prior contents.
